// File: rtl/vc_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : vc_arb_pkg
// Brief  : Shared owner encoding, default destination bit, weight helper.
// Rev    : 1.0  initial release
// ============================================================================
package vc_arb_pkg;

    localparam int DEST_BIT_DEF = 4;
    localparam int WGT_MAX_W    = 8;

    localparam logic OWNER_VC0 = 1'b0;
    localparam logic OWNER_VC1 = 1'b1;

    typedef enum logic [0:0] {
        SERVE0 = OWNER_VC0,
        SERVE1 = OWNER_VC1
    } owner_e;

    // A zero weight would starve its VC forever, so it is promoted to one credit.
    function automatic logic [WGT_MAX_W-1:0] wgt_nonzero(input logic [WGT_MAX_W-1:0] w);
        return (w == '0) ? WGT_MAX_W'(1) : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vc_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : vc_arbiter_if
// Brief  : VC-side flags/heads and pop/select outputs of the WRR arbiter.
//          Grant counters exist only when VC_ARB_STATS_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
interface vc_arbiter_if #(
    parameter int DATA_W = 6,
    parameter int WGT_W  = 3
);
    logic              init;
    logic              arb_en;
    logic [WGT_W-1:0]  weight_vc0_i;
    logic [WGT_W-1:0]  weight_vc1_i;
    logic              fifo_empty_vc0;
    logic              fifo_empty_vc1;
    logic [DATA_W-1:0] head_vc0;
    logic [DATA_W-1:0] head_vc1;
    logic              fifo_pause_d0;
    logic              fifo_pause_d1;
    logic              pop_vc0;
    logic              pop_vc1;
    logic              pop_delay_vc0;
    logic              pop_delay_vc1;
    logic              dest_out;
    logic              arb_idle;
`ifdef VC_ARB_STATS_EN
    logic [15:0]       grant_cnt_vc0;
    logic [15:0]       grant_cnt_vc1;
`endif

    modport master (
        output init, arb_en, weight_vc0_i, weight_vc1_i,
        output fifo_empty_vc0, fifo_empty_vc1, head_vc0, head_vc1,
        output fifo_pause_d0, fifo_pause_d1,
        input  pop_vc0, pop_vc1, pop_delay_vc0, pop_delay_vc1, dest_out, arb_idle
`ifdef VC_ARB_STATS_EN
        , input grant_cnt_vc0, grant_cnt_vc1
`endif
    );

    modport slave (
        input  init, arb_en, weight_vc0_i, weight_vc1_i,
        input  fifo_empty_vc0, fifo_empty_vc1, head_vc0, head_vc1,
        input  fifo_pause_d0, fifo_pause_d1,
        output pop_vc0, pop_vc1, pop_delay_vc0, pop_delay_vc1, dest_out, arb_idle
`ifdef VC_ARB_STATS_EN
        , output grant_cnt_vc0, grant_cnt_vc1
`endif
    );

endinterface
`default_nettype wire

// File: rtl/vc_credit_counter.sv
`default_nettype none
// ============================================================================
// Module : vc_credit_counter
// Brief  : Loadable credit down-counter; o_last flags that one decrement hits zero.
// Rev    : 1.0  initial release
// ============================================================================
module vc_credit_counter #(
    parameter int WGT_W = 3
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             i_load,
    input  logic [WGT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_last
);

    logic [WGT_W-1:0] r_count_q;
    logic [WGT_W-1:0] w_count_d;

    always_comb begin
        w_count_d = r_count_q;
        if (i_load) begin
            w_count_d = i_load_val;
        end else if (i_dec) begin
            w_count_d = r_count_q - WGT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_count_q <= WGT_W'(1);
        end else begin
            r_count_q <= w_count_d;
        end
    end

    assign o_last = (r_count_q == WGT_W'(1));

endmodule
`default_nettype wire

// File: rtl/vc_arbiter.sv
`default_nettype none
// ============================================================================
// Module : vc_arbiter
// Brief  : Weighted round-robin popper of VC0/VC1 toward D0/D1, pause aware.
//          Define VC_ARB_STATS_EN to add saturating per-VC grant counters.
// Rev    : 1.0  initial release
// ============================================================================
module vc_arbiter
    import vc_arb_pkg::*;
#(
    parameter int DATA_W   = 6,
    parameter int DEST_BIT = DEST_BIT_DEF,
    parameter int WGT_W    = 3
) (
    input  logic          clk,
    input  logic          reset_L,
    vc_arbiter_if.slave   bus
);

    owner_e           r_owner_q, w_owner_d;
    logic [WGT_W-1:0] r_wgt0_q, w_wgt0_d;
    logic [WGT_W-1:0] r_wgt1_q, w_wgt1_d;
    logic             r_pop_delay_vc0_q, w_pop_delay_vc0_d;
    logic             r_pop_delay_vc1_q, w_pop_delay_vc1_d;
    logic             r_dest_q, w_dest_d;

    logic [WGT_W-1:0] w_wgt0_new, w_wgt1_new;
    logic             w_pause_vc0, w_pause_vc1;
    logic             w_elig0, w_elig1;
    logic             w_pop0, w_pop1;
    logic             w_pop0_o, w_pop1_o;
    logic             w_cnt_load, w_cnt_dec, w_credit_last;
    logic [WGT_W-1:0] w_cnt_val;

    assign w_wgt0_new = WGT_W'(wgt_nonzero(WGT_MAX_W'(bus.weight_vc0_i)));
    assign w_wgt1_new = WGT_W'(wgt_nonzero(WGT_MAX_W'(bus.weight_vc1_i)));

    assign w_pause_vc0 = bus.head_vc0[DEST_BIT] ? bus.fifo_pause_d1 : bus.fifo_pause_d0;
    assign w_pause_vc1 = bus.head_vc1[DEST_BIT] ? bus.fifo_pause_d1 : bus.fifo_pause_d0;
    assign w_elig0     = bus.arb_en & ~bus.fifo_empty_vc0 & ~w_pause_vc0;
    assign w_elig1     = bus.arb_en & ~bus.fifo_empty_vc1 & ~w_pause_vc1;

    vc_credit_counter #(.WGT_W(WGT_W)) u_credit (
        .clk        (clk),
        .reset_L    (reset_L),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_dec      (w_cnt_dec),
        .o_last     (w_credit_last)
    );

    // The non-owner is served whenever the owner cannot pop; if its whole turn
    // is that single word, ownership snaps back with a fresh owner allowance.
    always_comb begin
        w_owner_d  = r_owner_q;
        w_wgt0_d   = r_wgt0_q;
        w_wgt1_d   = r_wgt1_q;
        w_pop0     = 1'b0;
        w_pop1     = 1'b0;
        w_cnt_load = 1'b0;
        w_cnt_dec  = 1'b0;
        w_cnt_val  = r_wgt0_q;
        if (bus.init) begin
            w_wgt0_d   = w_wgt0_new;
            w_wgt1_d   = w_wgt1_new;
            w_owner_d  = SERVE0;
            w_cnt_load = 1'b1;
            w_cnt_val  = w_wgt0_new;
        end else begin
            unique case (r_owner_q)
                SERVE0: begin
                    if (w_elig0) begin
                        w_pop0 = 1'b1;
                        if (w_credit_last) begin
                            w_owner_d  = SERVE1;
                            w_cnt_load = 1'b1;
                            w_cnt_val  = r_wgt1_q;
                        end else begin
                            w_cnt_dec = 1'b1;
                        end
                    end else if (w_elig1) begin
                        w_pop1     = 1'b1;
                        w_cnt_load = 1'b1;
                        if (r_wgt1_q == WGT_W'(1)) begin
                            w_owner_d = SERVE0;
                            w_cnt_val = r_wgt0_q;
                        end else begin
                            w_owner_d = SERVE1;
                            w_cnt_val = r_wgt1_q - WGT_W'(1);
                        end
                    end
                end
                SERVE1: begin
                    if (w_elig1) begin
                        w_pop1 = 1'b1;
                        if (w_credit_last) begin
                            w_owner_d  = SERVE0;
                            w_cnt_load = 1'b1;
                            w_cnt_val  = r_wgt0_q;
                        end else begin
                            w_cnt_dec = 1'b1;
                        end
                    end else if (w_elig0) begin
                        w_pop0     = 1'b1;
                        w_cnt_load = 1'b1;
                        if (r_wgt0_q == WGT_W'(1)) begin
                            w_owner_d = SERVE1;
                            w_cnt_val = r_wgt1_q;
                        end else begin
                            w_owner_d = SERVE0;
                            w_cnt_val = r_wgt0_q - WGT_W'(1);
                        end
                    end
                end
                default: w_owner_d = SERVE0;
            endcase
        end
    end

    // Reset must kill the pop combinationally so no word leaves mid-reset.
    assign w_pop0_o = w_pop0 & reset_L;
    assign w_pop1_o = w_pop1 & reset_L;

    always_comb begin
        w_pop_delay_vc0_d = w_pop0_o;
        w_pop_delay_vc1_d = w_pop1_o;
        w_dest_d          = 1'b0;
        if (w_pop0_o) begin
            w_dest_d = bus.head_vc0[DEST_BIT];
        end else if (w_pop1_o) begin
            w_dest_d = bus.head_vc1[DEST_BIT];
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_owner_q         <= SERVE0;
            r_wgt0_q          <= WGT_W'(1);
            r_wgt1_q          <= WGT_W'(1);
            r_pop_delay_vc0_q <= 1'b0;
            r_pop_delay_vc1_q <= 1'b0;
            r_dest_q          <= 1'b0;
        end else begin
            r_owner_q         <= w_owner_d;
            r_wgt0_q          <= w_wgt0_d;
            r_wgt1_q          <= w_wgt1_d;
            r_pop_delay_vc0_q <= w_pop_delay_vc0_d;
            r_pop_delay_vc1_q <= w_pop_delay_vc1_d;
            r_dest_q          <= w_dest_d;
        end
    end

    assign bus.pop_vc0       = w_pop0_o;
    assign bus.pop_vc1       = w_pop1_o;
    assign bus.pop_delay_vc0 = r_pop_delay_vc0_q;
    assign bus.pop_delay_vc1 = r_pop_delay_vc1_q;
    assign bus.dest_out      = r_dest_q;
    assign bus.arb_idle      = bus.fifo_empty_vc0 & bus.fifo_empty_vc1 & ~w_pop0_o & ~w_pop1_o;

`ifdef VC_ARB_STATS_EN
    logic [15:0] r_grant_cnt_vc0_q, w_grant_cnt_vc0_d;
    logic [15:0] r_grant_cnt_vc1_q, w_grant_cnt_vc1_d;

    always_comb begin
        w_grant_cnt_vc0_d = r_grant_cnt_vc0_q;
        w_grant_cnt_vc1_d = r_grant_cnt_vc1_q;
        if (bus.init) begin
            w_grant_cnt_vc0_d = '0;
            w_grant_cnt_vc1_d = '0;
        end else begin
            if (w_pop0_o && (r_grant_cnt_vc0_q != 16'hFFFF)) begin
                w_grant_cnt_vc0_d = r_grant_cnt_vc0_q + 16'd1;
            end
            if (w_pop1_o && (r_grant_cnt_vc1_q != 16'hFFFF)) begin
                w_grant_cnt_vc1_d = r_grant_cnt_vc1_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_grant_cnt_vc0_q <= '0;
            r_grant_cnt_vc1_q <= '0;
        end else begin
            r_grant_cnt_vc0_q <= w_grant_cnt_vc0_d;
            r_grant_cnt_vc1_q <= w_grant_cnt_vc1_d;
        end
    end

    assign bus.grant_cnt_vc0 = r_grant_cnt_vc0_q;
    assign bus.grant_cnt_vc1 = r_grant_cnt_vc1_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vc_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_vc_arbiter
// Brief  : Scoreboard bench for vc_arbiter; grant counters are also checked
//          when VC_ARB_STATS_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
module tb_vc_arbiter;

    logic clk = 1'b0;
    logic reset_L = 1'b0;
    always #5 clk = ~clk;

    vc_arbiter_if #(.DATA_W(6), .WGT_W(3)) bus ();

    vc_arbiter #(.DATA_W(6), .DEST_BIT(4), .WGT_W(3)) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus)
    );

    typedef struct packed {
        logic p0;
        logic p1;
        logic dst;
        logic idle;
    } exp_t;

    int   total = 0;
    int   bad   = 0;

    exp_t exp_q[$];
    exp_t prev;
    bit   prev_v = 0;
    bit   mon_en = 0;
    bit   rec_en = 0;
    bit   obs[$];

    logic [5:0] q0[$];
    logic [5:0] q1[$];
    bit   c_arb_en = 0, c_pause0 = 0, c_pause1 = 0, c_fill0 = 0, c_fill1 = 0;
    bit   pend0 = 0, pend1 = 0;

    // Reference scheduler: owner VC, words it has taken this turn, weights.
    int   m_own = 0, m_used = 0, m_w0 = 1, m_w1 = 1;
    int   g0 = 0, g1 = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [5:0] rand_word();
        return 6'($urandom);
    endfunction

    task automatic step(input bit do_init, input int wv0, input int wv1);
        logic [5:0] h0, h1;
        bit e0, e1, p0, p1;
        exp_t e;
        @(posedge clk);
        #1;
        if (pend0 && q0.size() != 0) void'(q0.pop_front());
        if (pend1 && q1.size() != 0) void'(q1.pop_front());
        while (c_fill0 && q0.size() < 4) q0.push_back(rand_word());
        while (c_fill1 && q1.size() < 4) q1.push_back(rand_word());
        h0 = (q0.size() != 0) ? q0[0] : rand_word();
        h1 = (q1.size() != 0) ? q1[0] : rand_word();
        bus.init           = do_init;
        bus.weight_vc0_i   = 3'(wv0);
        bus.weight_vc1_i   = 3'(wv1);
        bus.arb_en         = c_arb_en;
        bus.fifo_pause_d0  = c_pause0;
        bus.fifo_pause_d1  = c_pause1;
        bus.fifo_empty_vc0 = (q0.size() == 0);
        bus.fifo_empty_vc1 = (q1.size() == 0);
        bus.head_vc0       = h0;
        bus.head_vc1       = h1;
        e0 = c_arb_en && q0.size() != 0 && !(h0[4] ? c_pause1 : c_pause0);
        e1 = c_arb_en && q1.size() != 0 && !(h1[4] ? c_pause1 : c_pause0);
        p0 = 0;
        p1 = 0;
        if (do_init) begin
            m_w0 = (wv0 == 0) ? 1 : wv0;
            m_w1 = (wv1 == 0) ? 1 : wv1;
            m_own = 0;
            m_used = 0;
            g0 = 0;
            g1 = 0;
        end else if (m_own == 0) begin
            if (e0) begin
                p0 = 1; m_used++;
                if (m_used >= m_w0) begin m_own = 1; m_used = 0; end
            end else if (e1) begin
                p1 = 1;
                if (m_w1 == 1) begin m_own = 0; m_used = 0; end
                else begin m_own = 1; m_used = 1; end
            end
        end else begin
            if (e1) begin
                p1 = 1; m_used++;
                if (m_used >= m_w1) begin m_own = 0; m_used = 0; end
            end else if (e0) begin
                p0 = 1;
                if (m_w0 == 1) begin m_own = 1; m_used = 0; end
                else begin m_own = 0; m_used = 1; end
            end
        end
        if (p0) g0++;
        if (p1) g1++;
        e.p0   = p0;
        e.p1   = p1;
        e.dst  = p0 ? h0[4] : (p1 ? h1[4] : 1'b0);
        e.idle = (q0.size() == 0) && (q1.size() == 0) && !p0 && !p1;
        exp_q.push_back(e);
        pend0 = p0;
        pend1 = p1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("pop_vc0", 16'(bus.pop_vc0), 16'(e.p0));
            chk("pop_vc1", 16'(bus.pop_vc1), 16'(e.p1));
            chk("arb_idle", 16'(bus.arb_idle), 16'(e.idle));
            if (prev_v) begin
                chk("pop_delay_vc0", 16'(bus.pop_delay_vc0), 16'(prev.p0));
                chk("pop_delay_vc1", 16'(bus.pop_delay_vc1), 16'(prev.p1));
                if (prev.p0 || prev.p1) chk("dest_out", 16'(bus.dest_out), 16'(prev.dst));
            end
            if (rec_en && (bus.pop_vc0 || bus.pop_vc1)) obs.push_back(bus.pop_vc1);
            prev   = e;
            prev_v = 1;
        end
    end

    function automatic logic [15:0] pack_obs(input int n);
        logic [15:0] v = '0;
        for (int i = 0; i < n && i < obs.size(); i++) v[i] = obs[i];
        return v;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.init = 0; bus.arb_en = 1;
        bus.weight_vc0_i = '0; bus.weight_vc1_i = '0;
        bus.fifo_empty_vc0 = 0; bus.fifo_empty_vc1 = 0;
        bus.head_vc0 = 6'h05; bus.head_vc1 = 6'h12;
        bus.fifo_pause_d0 = 0; bus.fifo_pause_d1 = 0;
        repeat (2) @(negedge clk);
        chk("rst_pop_vc0", 16'(bus.pop_vc0), 16'd0);
        chk("rst_pop_vc1", 16'(bus.pop_vc1), 16'd0);
        chk("rst_delay_vc0", 16'(bus.pop_delay_vc0), 16'd0);
        chk("rst_delay_vc1", 16'(bus.pop_delay_vc1), 16'd0);
        chk("rst_dest_out", 16'(bus.dest_out), 16'd0);
        chk("rst_arb_idle", 16'(bus.arb_idle), 16'd0);
        bus.fifo_empty_vc0 = 1; bus.fifo_empty_vc1 = 1; bus.arb_en = 0;
        @(negedge clk);
        reset_L = 1;
        mon_en = 1; c_arb_en = 1;
        repeat (3) step(0, 0, 0);

        // Weighted turns 3/1 with both VCs kept non-empty.
        c_fill0 = 1; c_fill1 = 1;
        step(1, 3, 1);
        rec_en = 1; obs.delete();
        repeat (12) step(0, 0, 0);
        @(negedge clk); #1;
        rec_en = 0;
        chk("wrr31_count", 16'(obs.size()), 16'd12);
        chk("wrr31_seq", pack_obs(8), 16'b1000_1000);

        // Zero weight promoted to one: pattern 0,1,1.
        step(1, 0, 2);
        rec_en = 1; obs.delete();
        repeat (9) step(0, 0, 0);
        @(negedge clk); #1;
        rec_en = 0;
        chk("wrr02_seq", pack_obs(9), 16'b1_1011_0110);

        // Work-conserving: VC0 empty, VC1 holds exactly five words.
        c_arb_en = 0; c_fill0 = 0; c_fill1 = 0;
        step(0, 0, 0);
        q0.delete(); q1.delete();
        for (int i = 0; i < 5; i++) q1.push_back(rand_word());
        c_arb_en = 1;
        rec_en = 1; obs.delete();
        repeat (8) step(0, 0, 0);
        @(negedge clk); #1;
        rec_en = 0;
        chk("wc_count", 16'(obs.size()), 16'd5);
        chk("wc_seq", pack_obs(5), 16'b1_1111);

        // Pause: VC0 words go to paused D0, VC1 words to D1.
        c_arb_en = 0;
        step(0, 0, 0);
        q0.delete(); q1.delete();
        for (int i = 0; i < 6; i++) q0.push_back(rand_word() & 6'b10_1111);
        for (int i = 0; i < 3; i++) q1.push_back(rand_word() | 6'b01_0000);
        c_arb_en = 1; c_pause0 = 1;
        rec_en = 1; obs.delete();
        repeat (5) step(0, 0, 0);
        c_pause0 = 0;
        repeat (2) step(0, 0, 0);
        @(negedge clk); #1;
        rec_en = 0;
        chk("pause_seq", pack_obs(5), 16'b0_0111);

        // Randomized traffic, pauses, enable gaps and re-inits.
        for (int n = 0; n < 1500; n++) begin
            int r;
            c_arb_en = ($urandom_range(0, 9) != 0);
            c_pause0 = ($urandom_range(0, 3) == 0);
            c_pause1 = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 2);
            for (int k = 0; k < r; k++) if (q0.size() < 8) q0.push_back(rand_word());
            r = $urandom_range(0, 2);
            for (int k = 0; k < r; k++) if (q1.size() < 8) q1.push_back(rand_word());
            if ($urandom_range(0, 49) == 0) step(1, $urandom_range(0, 7), $urandom_range(0, 7));
            else step(0, 0, 0);
        end
`ifdef VC_ARB_STATS_EN
        @(negedge clk); #1;
        @(posedge clk); #1;
        chk("grant_cnt_vc0", bus.grant_cnt_vc0, 16'(g0 - (pend0 ? 0 : 0)));
        chk("grant_cnt_vc1", bus.grant_cnt_vc1, 16'(g1));
        pend0 = 0; pend1 = 0;
        exp_q.delete(); prev_v = 0;
        m_own = m_own; // state unchanged: the skipped cycle is replayed below
`endif

        // Asynchronous reset in the middle of a pop.
        c_arb_en = 1; c_pause0 = 0; c_pause1 = 0; c_fill0 = 1; c_fill1 = 1;
`ifdef VC_ARB_STATS_EN
        step(1, 1, 1);
`endif
        step(0, 0, 0);
        step(0, 0, 0);
        @(negedge clk); #1;
        step(0, 0, 0);
        #2;
        mon_en = 0;
        reset_L = 0;
        #1;
        chk("midrst_pop_vc0", 16'(bus.pop_vc0), 16'd0);
        chk("midrst_pop_vc1", 16'(bus.pop_vc1), 16'd0);
        @(posedge clk); #1;
        chk("midrst_delay_vc0", 16'(bus.pop_delay_vc0), 16'd0);
        chk("midrst_delay_vc1", 16'(bus.pop_delay_vc1), 16'd0);
`ifdef VC_ARB_STATS_EN
        chk("midrst_cnt_vc0", bus.grant_cnt_vc0, 16'd0);
        chk("midrst_cnt_vc1", bus.grant_cnt_vc1, 16'd0);
`endif
        pend0 = 0; pend1 = 0;
        exp_q.delete(); prev_v = 0;
        m_own = 0; m_used = 0; m_w0 = 1; m_w1 = 1; g0 = 0; g1 = 0;
        bus.arb_en = 0;
        @(negedge clk);
        reset_L = 1;
        mon_en = 1;
        for (int n = 0; n < 300; n++) begin
            c_arb_en = ($urandom_range(0, 7) != 0);
            c_pause0 = ($urandom_range(0, 4) == 0);
            c_pause1 = ($urandom_range(0, 4) == 0);
            c_fill0  = ($urandom_range(0, 1) != 0);
            c_fill1  = ($urandom_range(0, 1) != 0);
            step(0, 0, 0);
        end
        @(negedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
